ps2_key_fifo: RTL and testbench

- Bus-side capture buffer between the PS2_Keyboard controller and the MIO bus.
- Replaces the fixed 4-byte key_d shift logic and the ad-hoc ps2_rdn register with a parametrised block containing:
  - a pull handshake FSM toward the keyboard controller;
  - a DEPTH-entry scan-code FIFO that the CPU pops by polling;
  - a sticky overflow flag;
  - a HIST-byte history window for the 7-seg test display.
- Runs on the CPU I/O clock; the keyboard controller is driven from the same clock domain.

---
 rtl/ps2_key_fifo.sv | 144 ++++++++++++++
 tb/tb_ps2_key_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_fifo.sv
// rtl/ps2_key_fifo.sv - PS/2 scan-code pull FSM, FIFO, sticky overflow and history window
// Optional macro PS2_BREAK_FILTER_EN drops F0 break prefixes together with the byte that follows them.
module ps2_key_fifo #(
    parameter int          DEPTH       = 16,
    parameter int          HIST        = 4,
    parameter logic [7:0]  DEFAULT_KEY = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               kb_data,
    input  logic                     kb_ready,
    output logic                     kb_rdn,
    input  logic                     rd,
    output logic [7:0]               key_out,
    output logic                     key_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [8*HIST-1:0]        history
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          capture;
    logic          accept;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic          pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            kb_rdn <= 1'b1;
        end else begin
            state  <= state_nxt;
            kb_rdn <= (state_nxt != S_ACK);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (kb_ready) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign capture = (state == S_ACK);

`ifdef PS2_BREAK_FILTER_EN
    logic break_pend;

    // E0 is always kept and leaves a pending break untouched
    always_comb begin
        accept = 1'b1;
        if (kb_data != 8'hE0 && (break_pend || kb_data == 8'hF0))
            accept = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            break_pend <= 1'b0;
        else if (capture && kb_data != 8'hE0)
            break_pend <= !break_pend && (kb_data == 8'hF0);
    end
`else
    assign accept = 1'b1;
`endif

    assign full    = (count == CW'(DEPTH));
    assign push_ok = capture && accept && (!full || rd);
    assign drop    = capture && accept && full && !rd;
    assign pop     = rd && (count != '0);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= kb_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                count <= count + CW'(1);
            else if (!push_ok && pop)
                count <= count - CW'(1);
        end
    end

    // A drop on the same edge wins over a clear request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

    generate
        if (HIST == 1) begin : g_hist_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    history <= '0;
                else if (push_ok)
                    history <= kb_data;
            end
        end else begin : g_hist_many
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    history <= '0;
                else if (push_ok)
                    history <= {history[8*HIST-9:0], kb_data};
            end
        end
    endgenerate

    assign key_valid = (count != '0);
    assign key_out   = key_valid ? mem[rd_ptr] : DEFAULT_KEY;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb/tb_ps2_key_fifo.sv - randomized and directed self-checking bench for ps2_key_fifo
module tb_ps2_key_fifo;

    localparam int         DEPTH = 16;
    localparam int         HIST  = 4;
    localparam logic [7:0] DEF   = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  kb_data = 8'h00;
    logic        kb_ready = 1'b0;
    logic        kb_rdn;
    logic        rd = 1'b0;
    logic [7:0]  key_out;
    logic        key_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [31:0] history;

    ps2_key_fifo #(.DEPTH(DEPTH), .HIST(HIST), .DEFAULT_KEY(DEF)) dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready), .kb_rdn(kb_rdn),
        .rd(rd), .key_out(key_out), .key_valid(key_valid), .count(count),
        .overflow(overflow), .ovf_clr(ovf_clr), .history(history)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  kb_q[$];
    logic [7:0]  mq[$];
    logic [31:0] mh;
    logic        movf;
    logic        mpend;
    int          mph;
    logic [7:0]  mb;
    int          mhad;
    logic        mkeep;
    logic        mdrop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte source queue, occupancy queue and history shift, one cycle per edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mh    = '0;
            movf  = 1'b0;
            mpend = 1'b0;
            mph   = 0;
        end else begin
            mhad  = mq.size();
            mkeep = 1'b0;
            mdrop = 1'b0;
            if (rd && mhad > 0)
                void'(mq.pop_front());
            if (mph == 1) begin
                mb = kb_data;
                if (kb_q.size() > 0)
                    void'(kb_q.pop_front());
                mkeep = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                if (mb != 8'hE0) begin
                    if (mpend) begin
                        mkeep = 1'b0;
                        mpend = 1'b0;
                    end else if (mb == 8'hF0) begin
                        mkeep = 1'b0;
                        mpend = 1'b1;
                    end
                end
`endif
            end
            if (mkeep) begin
                if (mhad < DEPTH || rd) begin
                    mq.push_back(mb);
                    mh = {mh[23:0], mb};
                end else begin
                    mdrop = 1'b1;
                end
            end
            if (mdrop)
                movf = 1'b1;
            else if (ovf_clr)
                movf = 1'b0;
            if (mph == 1)
                mph = 2;
            else if (mph == 2)
                mph = 0;
            else
                mph = kb_ready ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        chk("kb_rdn", kb_rdn, (mph != 1));
        chk("count", count, mq.size());
        chk("key_valid", key_valid, (mq.size() != 0));
        if (mq.size() != 0)
            chk("key_out", key_out, mq[0]);
        else
            chk("key_out_empty", key_out, DEF);
        chk("overflow", overflow, movf);
        chk("history", history, mh);
    end

    task automatic step();
        @(posedge clk);
        #1;
        kb_ready = (kb_q.size() != 0);
        if (kb_q.size() != 0)
            kb_data = kb_q[0];
        else
            kb_data = 8'h00;
    endtask

    task automatic drain();
        int n = 0;
        while ((kb_q.size() != 0 || mph != 0) && n < 300) begin
            step();
            n++;
        end
        chk("drain_timeout", (n < 300), 1);
    endtask

    task automatic pop_all();
        int n = 0;
        rd = 1'b1;
        while (mq.size() != 0 && n < DEPTH + 4) begin
            step();
            n++;
        end
        rd = 1'b0;
        step();
        chk("pop_all_count", count, 0);
    endtask

    int         lows;
    logic [7:0] pick;

    initial begin
        // reset abandons a handshake that is mid-ACK
        step();
        step();
        chk("rst_kb_rdn", kb_rdn, 1);
        chk("rst_key_out", key_out, DEF);
        rst = 1'b0;
        kb_q.push_back(8'h33);
        for (int i = 0; i < 10 && mph != 1; i++)
            step();
        chk("reach_ack", kb_rdn, 0);
        rst = 1'b1;
        kb_q.delete();
        kb_ready = 1'b0;
        #1;
        chk("midack_kb_rdn", kb_rdn, 1);
        chk("midack_count", count, 0);
        chk("midack_key_out", key_out, DEF);
        chk("midack_history", history, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            step();
        chk("post_rst_count", count, 0);

        // back-to-back stream: one ACK every 3 cycles
        kb_q.push_back(8'h1C);
        kb_q.push_back(8'h32);
        kb_q.push_back(8'h21);
        lows = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (kb_rdn == 1'b0)
                lows++;
            if (i == 3) begin
                chk("first_key_out", key_out, 8'h1C);
                chk("first_count", count, 1);
            end
        end
        chk("stream_lows", lows, 3);
        chk("stream_count", count, 3);
        chk("stream_history", history, 32'h001C3221);

        // fill to DEPTH, then a drop
        pop_all();
        for (int i = 0; i < DEPTH; i++)
            kb_q.push_back(8'h10 + 8'(i));
        drain();
        chk("fill_count", count, 16);
        kb_q.push_back(8'h5A);
        drain();
        chk("drop_count", count, 16);
        chk("drop_overflow", overflow, 1);
        chk("drop_history", history[7:0], 8'h1F);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step();
        chk("ovf_cleared", overflow, 0);

        // full with rd on the push edge stores the byte
        kb_q.push_back(8'h5B);
        for (int n = 0; n < 20 && (kb_q.size() != 0 || mph != 0); n++) begin
            step();
            rd = (mph == 1);
        end
        rd = 1'b0;
        step();
        chk("rdpush_count", count, 16);
        chk("rdpush_overflow", overflow, 0);
        chk("rdpush_history", history[7:0], 8'h5B);
        chk("rdpush_key_out", key_out, 8'h11);

        // set beats clear on the same edge
        kb_q.push_back(8'h5C);
        drain();
        chk("ovf_set", overflow, 1);
        kb_q.push_back(8'h5D);
        for (int n = 0; n < 20 && (kb_q.size() != 0 || mph != 0); n++) begin
            step();
            ovf_clr = (mph == 1);
        end
        ovf_clr = 1'b0;
        step();
        chk("ovf_priority", overflow, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        step();
        chk("ovf_clr_next", overflow, 0);

        // underflow reads are ignored, then pointer wrap
        pop_all();
        rd = 1'b1;
        for (int i = 0; i < 4; i++)
            step();
        rd = 1'b0;
        step();
        chk("underflow_count", count, 0);
        chk("underflow_valid", key_valid, 0);
        chk("underflow_key", key_out, DEF);
        for (int i = 0; i < DEPTH + 3; i++) begin
            kb_q.push_back(8'h80 + 8'(i));
            drain();
            chk("wrap_key", key_out, 8'h80 + 8'(i));
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        step();
        chk("wrap_count", count, 0);

        // break-code stream
        kb_q.push_back(8'h1C);
        kb_q.push_back(8'hF0);
        kb_q.push_back(8'h1C);
        kb_q.push_back(8'hE0);
        kb_q.push_back(8'hF0);
        kb_q.push_back(8'h75);
        drain();
`ifdef PS2_BREAK_FILTER_EN
        chk("filter_count", count, 2);
        chk("filter_history", history[15:0], 16'h1CE0);
`else
        chk("filter_count", count, 6);
        chk("filter_history", history, 32'h1CE0F075);
`endif
        chk("filter_head", key_out, 8'h1C);
        pop_all();

        // randomized traffic at two read rates
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && kb_q.size() < 4) begin
                case ($urandom_range(0, 9))
                    0:       pick = 8'hF0;
                    1:       pick = 8'hE0;
                    default: pick = 8'($urandom_range(0, 255));
                endcase
                kb_q.push_back(pick);
            end
            rd      = ($urandom_range(0, 99) < ((i < 1500) ? 12 : 45));
            ovf_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        rd      = 1'b0;
        ovf_clr = 1'b0;
        drain();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
